sample_circuit: RTL and testbench

//   Three-input single-bit logic cell, the leaf function block of the ALU datapath.
//   - Evaluates a parameterised 3-input truth table combinationally on y.
//   - Provides a registered copy, an edge pulse, and optional activity statistics.
//   - Default table is 3-input majority (carry-out of a full adder).

---
 rtl/sample_circuit.sv | 73 +++++++
 tb/tb_sample_circuit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sample_circuit.sv
// rtl/sample_circuit.sv - parameterised 3-input logic cell with registered copy, rise pulse and optional stats
//
// Parameters:
//   TRUTH_TABLE  bit i is y for {a,b,c}==i (a is MSB); default 8'hE8 = majority
//   CNT_W        width of the statistics counters (>=2)
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   a, b, c   operand bits ({a,b,c} indexes TRUTH_TABLE, a is MSB)
//   y         combinational result TRUTH_TABLE[{a,b,c}]
//   y_q       y registered on clk
//   y_rise    one-cycle pulse when y_q rises
//   ones_cnt  saturating count of sampled edges with y==1
//   eval_cnt  saturating count of sampled edges since reset
// Configuration macro: SAMPLECIRCUIT_STATS_EN enables the counters; when
// undefined, ones_cnt and eval_cnt are tied to 0 and the port list is unchanged.

module sample_circuit #(
    parameter logic [7:0] TRUTH_TABLE = 8'hE8,
    parameter int         CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             y,
    output logic             y_q,
    output logic             y_rise,
    output logic [CNT_W-1:0] ones_cnt,
    output logic [CNT_W-1:0] eval_cnt
);

    logic [2:0] sel;

    // No masking: an X/Z on any operand propagates to y through the index.
    assign sel = {a, b, c};
    assign y   = TRUTH_TABLE[sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q    <= 1'b0;
            y_rise <= 1'b0;
        end else begin
            y_q    <= y;
            // Compares against the previous y_q so the pulse lasts one cycle.
            y_rise <= y & ~y_q;
        end
    end

`ifdef SAMPLECIRCUIT_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt <= '0;
            eval_cnt <= '0;
        end else begin
            // Both counters stick at all-ones rather than wrapping.
            if (eval_cnt != CNT_MAX) begin
                eval_cnt <= eval_cnt + 1'b1;
            end
            if (y && (ones_cnt != CNT_MAX)) begin
                ones_cnt <= ones_cnt + 1'b1;
            end
        end
    end
`else
    assign ones_cnt = '0;
    assign eval_cnt = '0;
`endif

endmodule

// File: tb/tb_sample_circuit.sv
// tb/tb_sample_circuit.sv - directed self-checking bench for sample_circuit

module tb_sample_circuit;

    logic       clk;
    logic       rst_n;
    logic       a, b, c;
    logic       y, y_q, y_rise;
    logic [7:0] ones_cnt, eval_cnt;

    logic       x_y, x_y_q, x_y_rise;
    logic [7:0] x_ones_cnt, x_eval_cnt;

    logic       s_rst_n;
    logic       s_a, s_b, s_c;
    logic       s_y, s_y_q, s_y_rise;
    logic [1:0] s_ones_cnt, s_eval_cnt;

    int total;
    int bad;

    sample_circuit u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .c        (c),
        .y        (y),
        .y_q      (y_q),
        .y_rise   (y_rise),
        .ones_cnt (ones_cnt),
        .eval_cnt (eval_cnt)
    );

    sample_circuit #(.TRUTH_TABLE(8'h96)) u_xor (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .c        (c),
        .y        (x_y),
        .y_q      (x_y_q),
        .y_rise   (x_y_rise),
        .ones_cnt (x_ones_cnt),
        .eval_cnt (x_eval_cnt)
    );

    sample_circuit #(.CNT_W(2)) u_sat (
        .clk      (clk),
        .rst_n    (s_rst_n),
        .a        (s_a),
        .b        (s_b),
        .c        (s_c),
        .y        (s_y),
        .y_q      (s_y_q),
        .y_rise   (s_y_rise),
        .ones_cnt (s_ones_cnt),
        .eval_cnt (s_eval_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] maj_exp;
    logic [7:0] xor_exp;
`ifdef SAMPLECIRCUIT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        s_rst_n = 1'b0;
        {a, b, c}       = 3'b000;
        {s_a, s_b, s_c} = 3'b111;
        // Hand-written expectations, index 0..7 = {a,b,c}.
        // majority: 0,0,0,1,0,1,1,1 ; xor: 0,1,1,0,1,0,0,1
        maj_exp = 8'b1110_1000;
        xor_exp = 8'b1001_0110;

        // Combinational sweep while held in reset.
        for (int i = 0; i < 8; i++) begin
            {a, b, c} = i[2:0];
            #1;
            check($sformatf("maj_y_%0d", i), {31'd0, y}, {31'd0, maj_exp[i]});
            check($sformatf("xor_y_%0d", i), {31'd0, x_y}, {31'd0, xor_exp[i]});
            #9;
        end

        // Reset state after several edges in reset.
        check("rst_y_q", {31'd0, y_q}, 32'd0);
        check("rst_y_rise", {31'd0, y_rise}, 32'd0);
        check("rst_ones", {24'd0, ones_cnt}, 32'd0);
        check("rst_eval", {24'd0, eval_cnt}, 32'd0);

        // Release reset with 011 held, then drop to 000.
        tick();
        rst_n = 1'b1;
        {a, b, c} = 3'b011;
        #1;
        check("rel_y", {31'd0, y}, 32'd1);
        check("rel_y_q_pre", {31'd0, y_q}, 32'd0);
        tick();
        check("e1_y_q", {31'd0, y_q}, 32'd1);
        check("e1_rise", {31'd0, y_rise}, 32'd1);
        tick();
        check("e2_y_q", {31'd0, y_q}, 32'd1);
        check("e2_rise", {31'd0, y_rise}, 32'd0);
        {a, b, c} = 3'b000;
        #1;
        check("chg_y", {31'd0, y}, 32'd0);
        check("chg_y_q_hold", {31'd0, y_q}, 32'd1);
        tick();
        check("e3_y_q", {31'd0, y_q}, 32'd0);
        check("e3_rise", {31'd0, y_rise}, 32'd0);
        tick();
        check("e4_eval", {24'd0, eval_cnt}, STATS ? 32'd4 : 32'd0);
        check("e4_ones", {24'd0, ones_cnt}, STATS ? 32'd2 : 32'd0);

        // Asynchronous reset mid-cycle with y_q=1.
        {a, b, c} = 3'b111;
        tick();
        check("pre_ar_y_q", {31'd0, y_q}, 32'd1);
        check("pre_ar_rise", {31'd0, y_rise}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("ar_y_q", {31'd0, y_q}, 32'd0);
        check("ar_rise", {31'd0, y_rise}, 32'd0);
        check("ar_ones", {24'd0, ones_cnt}, 32'd0);
        check("ar_eval", {24'd0, eval_cnt}, 32'd0);
        check("ar_y", {31'd0, y}, 32'd1);
        {a, b, c} = 3'b010;
        #1;
        check("ar_y_010", {31'd0, y}, 32'd0);
        {a, b, c} = 3'b101;
        #1;
        check("ar_y_101", {31'd0, y}, 32'd1);

        // Release with y=0: no pulse at the first edge.
        {a, b, c} = 3'b000;
        rst_n = 1'b1;
        tick();
        check("rel0_y_q", {31'd0, y_q}, 32'd0);
        check("rel0_rise", {31'd0, y_rise}, 32'd0);
        check("rel0_eval", {24'd0, eval_cnt}, STATS ? 32'd1 : 32'd0);
        {a, b, c} = 3'b110;
        tick();
        check("rel0_rise2", {31'd0, y_rise}, 32'd1);

        // Saturation with CNT_W=2 and 111 held five edges.
        s_rst_n = 1'b1;
        tick();
        tick();
        check("sat_eval_2", {30'd0, s_eval_cnt}, STATS ? 32'd2 : 32'd0);
        tick();
        tick();
        tick();
        check("sat_eval_5", {30'd0, s_eval_cnt}, STATS ? 32'd3 : 32'd0);
        check("sat_ones_5", {30'd0, s_ones_cnt}, STATS ? 32'd3 : 32'd0);
        check("sat_y_q", {31'd0, s_y_q}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
